alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  instruction and operands present
- in_ready  out  1  stage can accept
- instr  in  32  MIPS instruction word
- rs_data  in  32  register rs value
- rt_data  in  32  register rt value
- out_valid  out  1  decoded bundle present
- out_ready  in  1  ALU/execute stage accepts
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_ctrl  out  4  ALU control code
- wb_reg  out  5  destination register
- wb_en  out  1  result written back
- illegal  out  1  bundle is an unsupported instruction
- illegal_cnt  out  8  saturating illegal-instruction count

Function
REQ-003 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-004 A transfer SHALL occur when in_valid && in_ready; the decoded bundle SHALL appear on the outputs with out_valid=1 on the next cycle (latency 1).
REQ-005 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-006 When out_ready=1 and no transfer occurs, out_valid SHALL clear next cycle; back-to-back transfers SHALL sustain one bundle per cycle.
REQ-007 R-type (op=0x00) funct mapping, A=rs, B=rt, wb_reg=rd: 0x20/0x21->0010; 0x22/0x23->0110; 0x24->0000; 0x25->0001; 0x26->0011; 0x27->1100; 0x2A->0111.
REQ-008 Shifts, wb_reg=rd, B=rt: sll 0x00->0100, srl 0x02->0101, sra 0x03->1000 with A={27'b0,shamt}; sllv 0x04->0100, srlv 0x06->0101, srav 0x07->1000 with A=rs.
REQ-009 I-type, A=rs, wb_reg=rt: addi 0x08/addiu 0x09->0010 and slti 0x0A->0111 with B=sign-extended imm16; andi 0x0C->0000, ori 0x0D->0001, xori 0x0E->0011 with B=zero-extended imm16.
REQ-010 Memory: lw 0x23 and sw 0x2B->0010, A=rs, B=sign-extended imm16; lw wb_en=1 wb_reg=rt; sw wb_en=0.
REQ-011 Branches: beq 0x04->1001, bne 0x05->1010, A=rs, B=rt, wb_en=0, wb_reg=0.
REQ-012 wb_en SHALL be 1 for every write-back instruction except when wb_reg=0 (writes to $0 suppressed).
REQ-013 Any other opcode or R-type funct SHALL yield illegal=1, alu_ctrl=0010, alu_a=0, alu_b=0, wb_reg=0, wb_en=0; legal bundles SHALL have illegal=0.
REQ-014 illegal_cnt SHALL increment by 1 on each accepted illegal instruction, saturate at 255, and never wrap.
REQ-015 Decode SHALL depend only on instr, rs_data, rt_data sampled at transfer; input changes without transfer SHALL not affect outputs.

Reset
REQ-016 On reset: out_valid=0, alu_a=0, alu_b=0, alu_ctrl=0000, wb_reg=0, wb_en=0, illegal=0, illegal_cnt=0; hence in_ready=1 in the cycle after reset.
REQ-017 Reset asserted mid-stall SHALL discard the held bundle; in_valid during reset SHALL not transfer.

Verification
REQ-018 add $3,$1,$2 (0x00221820), rs=5, rt=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0010, A=5, B=7, wb_reg=3, wb_en=1.
REQ-019 sra $4,$5,3 (0x000520C3), rt=0x80000000 -> alu_ctrl=1000, A=3, B=0x80000000, wb_reg=4; addi $2,$1,-1 (0x2022FFFF) -> B=0xFFFFFFFF; ori $2,$1,0xFFFF -> B=0x0000FFFF.
REQ-020 Stall: bundle held with out_ready=0 for 3 cycles while new in_valid -> in_ready=0, outputs unchanged, no second bundle lost; out_ready=1 -> second bundle next cycle.
REQ-021 beq (0x10220004) -> alu_ctrl=1001, wb_en=0; sw -> alu_ctrl=0010, wb_en=0; sll $0,$0,0 (0x00000000) -> wb_en=0, illegal=0.
REQ-022 260 accepted illegal words (op=0x3F) -> illegal=1 each, illegal_cnt=255 and stays there; reset -> illegal_cnt=0.
REQ-023 Reset during stall with out_valid=1 -> next cycle out_valid=0, all outputs zero, in_ready=1.

Source files
------------

// File: rtl/alu_decode_stage.sv
// ---------------------------------------------------------------------------
// alu_decode_stage
//
// Single-entry decode stage for a MIPS-style integer pipeline. An instruction
// word plus its two register operands is accepted through a valid/ready
// handshake, decoded into ALU operands, an ALU control code and a write-back
// target, and presented one cycle later on a registered output bundle that
// holds until the execute stage accepts it.
//
// Ports
//   clk          in   1  clock, all state updates on the rising edge
//   reset        in   1  synchronous active-high reset
//   in_valid     in   1  instruction and operands present
//   in_ready     out  1  stage can accept (empty, or bundle leaving now)
//   instr        in  32  instruction word
//   rs_data      in  32  register rs value
//   rt_data      in  32  register rt value
//   out_valid    out  1  decoded bundle present
//   out_ready    in   1  execute stage accepts the bundle
//   alu_a        out 32  ALU operand A
//   alu_b        out 32  ALU operand B
//   alu_ctrl     out  4  ALU control code
//   wb_reg       out  5  destination register
//   wb_en        out  1  result is written back
//   illegal      out  1  bundle is an unsupported instruction
//   illegal_cnt  out  8  saturating count of accepted illegal instructions
// ---------------------------------------------------------------------------
module alu_decode_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  output logic [4:0]        wb_reg,
  output logic              wb_en,
  output logic              illegal,
  output logic [7:0]        illegal_cnt
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_BEQ = 4'b1001;
  localparam logic [3:0] ALU_BNE = 4'b1010;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Immediate and shift-amount widening helpers
  function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] imm);
    logic signed [15:0] simm;
    simm = imm;
    return DATA_W'(simm);
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] imm);
    return {{(DATA_W-16){1'b0}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zext5(input logic [4:0] sh);
    return {{(DATA_W-5){1'b0}}, sh};
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [4:0]  shamt;
  logic [15:0] imm16;

  assign op     = instr[31:26];
  assign rt_idx = instr[20:16];
  assign rd_idx = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm16  = instr[15:0];

  // Combinational decode of the word currently on the input
  logic [DATA_W-1:0] dec_a;
  logic [DATA_W-1:0] dec_b;
  logic [3:0]        dec_ctrl;
  logic [4:0]        dec_wb_reg;
  logic              dec_writes;
  logic              dec_wb_en;
  logic              dec_illegal;

  always_comb begin
    dec_a       = rs_data;
    dec_b       = rt_data;
    dec_ctrl    = ALU_ADD;
    dec_wb_reg  = 5'd0;
    dec_writes  = 1'b0;
    dec_illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        dec_wb_reg = rd_idx;
        dec_writes = 1'b1;
        case (funct)
          6'h20, 6'h21: dec_ctrl = ALU_ADD;
          6'h22, 6'h23: dec_ctrl = ALU_SUB;
          6'h24:        dec_ctrl = ALU_AND;
          6'h25:        dec_ctrl = ALU_OR;
          6'h26:        dec_ctrl = ALU_XOR;
          6'h27:        dec_ctrl = ALU_NOR;
          6'h2A:        dec_ctrl = ALU_SLT;
          // Constant shifts take the amount from the shamt field on A
          6'h00: begin dec_ctrl = ALU_SLL; dec_a = zext5(shamt); end
          6'h02: begin dec_ctrl = ALU_SRL; dec_a = zext5(shamt); end
          6'h03: begin dec_ctrl = ALU_SRA; dec_a = zext5(shamt); end
          6'h04:        dec_ctrl = ALU_SLL;
          6'h06:        dec_ctrl = ALU_SRL;
          6'h07:        dec_ctrl = ALU_SRA;
          default:      dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_b = sext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      OP_SLTI: begin
        dec_ctrl = ALU_SLT; dec_b = sext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      OP_ANDI: begin
        dec_ctrl = ALU_AND; dec_b = zext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      OP_ORI: begin
        dec_ctrl = ALU_OR; dec_b = zext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      OP_XORI: begin
        dec_ctrl = ALU_XOR; dec_b = zext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      OP_LW: begin
        dec_b = sext16(imm16); dec_wb_reg = rt_idx; dec_writes = 1'b1;
      end
      // Store computes the address only; rt is the data, not a destination
      OP_SW:  dec_b = sext16(imm16);
      OP_BEQ: dec_ctrl = ALU_BEQ;
      OP_BNE: dec_ctrl = ALU_BNE;
      default: dec_illegal = 1'b1;
    endcase
    // Illegal words are squashed to a harmless add of zeros with no write-back
    if (dec_illegal) begin
      dec_a      = '0;
      dec_b      = '0;
      dec_ctrl   = ALU_ADD;
      dec_wb_reg = 5'd0;
      dec_writes = 1'b0;
    end
  end

  // Writes to $0 are architecturally discarded, so never request them
  assign dec_wb_en = dec_writes && (dec_wb_reg != 5'd0);

  // Output bundle registers
  logic              vld_p1_q;
  logic [DATA_W-1:0] alu_a_p1_q,  alu_a_p1_d;
  logic [DATA_W-1:0] alu_b_p1_q,  alu_b_p1_d;
  logic [3:0]        ctrl_p1_q,   ctrl_p1_d;
  logic [4:0]        wb_reg_p1_q, wb_reg_p1_d;
  logic              wb_en_p1_q,  wb_en_p1_d;
  logic              ill_p1_q,    ill_p1_d;
  logic [7:0]        ill_cnt_q,   ill_cnt_d;
  logic              xfer;

  assign in_ready = !vld_p1_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Bundle fields only change on a transfer, so a stalled bundle holds
  always_comb begin
    alu_a_p1_d  = alu_a_p1_q;
    alu_b_p1_d  = alu_b_p1_q;
    ctrl_p1_d   = ctrl_p1_q;
    wb_reg_p1_d = wb_reg_p1_q;
    wb_en_p1_d  = wb_en_p1_q;
    ill_p1_d    = ill_p1_q;
    ill_cnt_d   = ill_cnt_q;
    if (xfer) begin
      alu_a_p1_d  = dec_a;
      alu_b_p1_d  = dec_b;
      ctrl_p1_d   = dec_ctrl;
      wb_reg_p1_d = dec_wb_reg;
      wb_en_p1_d  = dec_wb_en;
      ill_p1_d    = dec_illegal;
      if (dec_illegal) ill_cnt_d = sat_inc8(ill_cnt_q);
    end
  end

  // ---- stage boundary: decode -> registered output bundle ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1_q    <= 1'b0;
      alu_a_p1_q  <= '0;
      alu_b_p1_q  <= '0;
      ctrl_p1_q   <= 4'b0000;
      wb_reg_p1_q <= 5'd0;
      wb_en_p1_q  <= 1'b0;
      ill_p1_q    <= 1'b0;
      ill_cnt_q   <= 8'd0;
    end else begin
      if (xfer)           vld_p1_q <= 1'b1;
      else if (out_ready) vld_p1_q <= 1'b0;
      alu_a_p1_q  <= alu_a_p1_d;
      alu_b_p1_q  <= alu_b_p1_d;
      ctrl_p1_q   <= ctrl_p1_d;
      wb_reg_p1_q <= wb_reg_p1_d;
      wb_en_p1_q  <= wb_en_p1_d;
      ill_p1_q    <= ill_p1_d;
      ill_cnt_q   <= ill_cnt_d;
    end
  end

  assign out_valid   = vld_p1_q;
  assign alu_a       = alu_a_p1_q;
  assign alu_b       = alu_b_p1_q;
  assign alu_ctrl    = ctrl_p1_q;
  assign wb_reg      = wb_reg_p1_q;
  assign wb_en       = wb_en_p1_q;
  assign illegal     = ill_p1_q;
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_decode_stage
//
// Scoreboard bench: the driver pushes the model's expected bundle whenever a
// transfer happens; an independent monitor compares every presented bundle
// against the head of the queue and retires it when the consumer accepts.
// ---------------------------------------------------------------------------
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [4:0]  wb_reg;
  logic        wb_en;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .wb_reg(wb_reg), .wb_en(wb_en), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  wbr;
    logic        wbe;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt_m  = 0;
  bit   rand_rdy = 0;

  // Reference tables: funct -> ALU code for R-type, opcode -> code/kind
  bit [3:0] rctl  [int];
  int       rkind [int];   // 0 = register operands, 1 = shamt on A
  bit [3:0] ictl  [int];
  int       ikind [int];   // 0 sext+wb, 1 zext+wb, 2 load, 3 store, 4 branch

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int op, fn, kind;
    logic [31:0] se, ze;
    logic [4:0]  dst;
    bit writes;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    se = {{16{w[15]}}, w[15:0]};
    ze = {16'h0, w[15:0]};
    e.a = a; e.b = b; e.ctrl = 4'b0010; e.ill = 0;
    dst = 0; writes = 0;
    if (op == 0) begin
      if (rctl.exists(fn)) begin
        e.ctrl = rctl[fn]; dst = w[15:11]; writes = 1;
        if (rkind[fn] == 1) e.a = {27'd0, w[10:6]};
      end else e.ill = 1;
    end else if (ictl.exists(op)) begin
      e.ctrl = ictl[op];
      kind = ikind[op];
      if (kind == 1) e.b = ze;
      else if (kind != 4) e.b = se;
      if (kind <= 2) begin dst = w[20:16]; writes = 1; end
    end else e.ill = 1;
    if (e.ill) begin
      e.a = 0; e.b = 0; e.ctrl = 4'b0010; dst = 0; writes = 0;
      cnt_m = (cnt_m + 1 > 255) ? 255 : cnt_m + 1;
    end
    e.wbr = dst;
    e.wbe = writes && (dst != 0);
    e.cnt = 8'(cnt_m);
    return e;
  endfunction

  // Monitor: checks the handshake rule and the presented bundle each cycle
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_bundle", 32'd1, 32'd0);
        end else begin
          chk("alu_a", alu_a, sb[0].a);
          chk("alu_b", alu_b, sb[0].b);
          chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, sb[0].ctrl});
          chk("wb_reg", {27'd0, wb_reg}, {27'd0, sb[0].wbr});
          chk("wb_en", {31'd0, wb_en}, {31'd0, sb[0].wbe});
          chk("illegal", {31'd0, illegal}, {31'd0, sb[0].ill});
          chk("illegal_cnt", {24'd0, illegal_cnt}, {24'd0, sb[0].cnt});
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Present one instruction and hold it until it transfers
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    instr = w; rs_data = a; rt_data = b; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(w, a, b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom % 3) != 0;
    end
    chk("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    instr = $urandom; rs_data = $urandom; rt_data = $urandom;
    @(posedge clk); #1;
  endtask

  // Reset with in_valid asserted throughout; nothing may transfer
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; instr = 32'hFC00_0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0;
    sb.delete();
    cnt_m = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    chk("rst_wb", {26'd0, wb_reg, wb_en}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] rf [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h00, 6'h02, 6'h03, 6'h04};
    logic [5:0] io [11] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
                           6'h0E, 6'h23, 6'h2B, 6'h3F};
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 4)
      0: ;
      1: begin w[31:26] = 6'h00; w[5:0] = rf[$urandom % 13]; end
      2: w[31:26] = io[$urandom % 11];
      default: w[31:26] = 6'h00;
    endcase
    return w;
  endfunction

  initial begin
    rctl[32'h20] = 4'd2;  rctl[32'h21] = 4'd2;  rctl[32'h22] = 4'd6;  rctl[32'h23] = 4'd6;
    rctl[32'h24] = 4'd0;  rctl[32'h25] = 4'd1;  rctl[32'h26] = 4'd3;  rctl[32'h27] = 4'd12;
    rctl[32'h2A] = 4'd7;  rctl[32'h00] = 4'd4;  rctl[32'h02] = 4'd5;  rctl[32'h03] = 4'd8;
    rctl[32'h04] = 4'd4;  rctl[32'h06] = 4'd5;  rctl[32'h07] = 4'd8;
    foreach (rctl[k]) rkind[k] = (k <= 3) ? 1 : 0;
    ictl[32'h08] = 4'd2; ikind[32'h08] = 0;  ictl[32'h09] = 4'd2; ikind[32'h09] = 0;
    ictl[32'h0A] = 4'd7; ikind[32'h0A] = 0;  ictl[32'h0C] = 4'd0; ikind[32'h0C] = 1;
    ictl[32'h0D] = 4'd1; ikind[32'h0D] = 1;  ictl[32'h0E] = 4'd3; ikind[32'h0E] = 1;
    ictl[32'h23] = 4'd2; ikind[32'h23] = 2;  ictl[32'h2B] = 4'd2; ikind[32'h2B] = 3;
    ictl[32'h04] = 4'd9; ikind[32'h04] = 4;  ictl[32'h05] = 4'd10; ikind[32'h05] = 4;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    instr = 0; rs_data = 0; rt_data = 0;
    do_reset();

    // Directed decodes with constant expectations
    send(32'h0022_1820, 32'd5, 32'd7);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
    chk("add_ab", alu_a + (alu_b << 8), 32'd5 + (32'd7 << 8));
    chk("add_wb", {26'd0, wb_reg, wb_en}, {26'd0, 5'd3, 1'b1});
    send(32'h0005_20C3, 32'h1234_5678, 32'h8000_0000);
    chk("sra_ctrl", {28'd0, alu_ctrl}, 32'h8);
    chk("sra_a", alu_a, 32'd3);
    chk("sra_b", alu_b, 32'h8000_0000);
    chk("sra_wb_reg", {27'd0, wb_reg}, 32'd4);
    send(32'h2022_FFFF, 32'd1, 32'd2);
    chk("addi_b", alu_b, 32'hFFFF_FFFF);
    send(32'h3422_FFFF, 32'd1, 32'd2);
    chk("ori_b", alu_b, 32'h0000_FFFF);
    send(32'h1022_0004, 32'd1, 32'd1);
    chk("beq", {27'd0, alu_ctrl, wb_en}, {27'd0, 4'h9, 1'b0});
    send(32'hAC22_0004, 32'd1, 32'd2);
    chk("sw", {27'd0, alu_ctrl, wb_en}, {27'd0, 4'h2, 1'b0});
    send(32'h0000_0000, 32'd9, 32'd9);
    chk("nop", {30'd0, wb_en, illegal}, 32'd0);

    // Stall: hold a bundle for 3 cycles while a second word waits
    send(32'h0022_1822, 32'd10, 32'd4);
    out_ready = 1'b0;
    instr = 32'h0043_2025; rs_data = 32'hA; rt_data = 32'h5; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      instr = 32'h0043_2025; rs_data = 32'hA; rt_data = 32'h5;
    end
    out_ready = 1'b1;
    send(32'h0043_2025, 32'hA, 32'h5);
    chk("stall_second", {27'd0, wb_reg}, 32'd4);
    chk("stall_second_b", alu_b, 32'h5);

    // Randomized traffic with random back-pressure and idle gaps
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom % 3) != 0;
      if ($urandom % 4 == 0) idle_cycle();
      send(rand_instr(), $urandom, $urandom);
    end
    rand_rdy = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 32'd0);

    // Reset while a bundle is stalled
    send(32'h0022_1820, 32'd1, 32'd2);
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    out_ready = 1'b1;

    // Illegal-count saturation
    for (int i = 0; i < 260; i++) send(32'hFC00_0000 | ($urandom & 32'h03FF_FFFF), $urandom, $urandom);
    chk("sat_illegal", {31'd0, illegal}, 32'd1);
    chk("sat_cnt", {24'd0, illegal_cnt}, 32'd255);
    repeat (3) idle_cycle();
    chk("sat_cnt_hold", {24'd0, illegal_cnt}, 32'd255);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
